// File: rtl/quant_mcu_sequencer.sv
// quant_mcu_sequencer: issues Y/Cb/Cr quantizer enables in 4:2:0 MCU order,
// gated by downstream credits, and tags each quantizer output from a FIFO.
module quant_mcu_sequencer #(
    parameter int Y_PER_MCU = 4,
    parameter int CREDITS   = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num_mcus,
    input  logic        y_valid,
    output logic        y_ready,
    input  logic        cb_valid,
    output logic        cb_ready,
    input  logic        cr_valid,
    output logic        cr_ready,
    output logic        y_q_en,
    output logic        cb_q_en,
    output logic        cr_q_en,
    input  logic        y_q_done,
    input  logic        cb_q_done,
    input  logic        cr_q_done,
    input  logic        credit_return,
    output logic        out_valid,
    output logic [1:0]  out_comp,
    output logic [1:0]  out_blk,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int AW = $clog2(TAG_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE_Y, S_ISSUE_CB, S_ISSUE_CR, S_DRAIN} state_t;

    typedef struct packed {
        logic [1:0] comp;
        logic [1:0] blk;
        logic       last;
    } tag_t;

    state_t      state, state_nxt;
    logic [15:0] num_mcus_r;
    logic [15:0] mcu_cnt, mcu_cnt_nxt;
    logic [1:0]  y_idx, y_idx_nxt;
    logic [3:0]  credits;
    logic        done_nxt;
    logic        start_acc;

    tag_t        fifo [TAG_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] fifo_cnt;
    logic        fifo_empty, fifo_full;
    tag_t        head, push_tag;

    logic        can_issue, issue, any_done, pop, multi_done, cr_ovf, err_evt;
    logic [1:0]  done_comp;

    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = fifo[rd_ptr[AW-1:0]];

    // Only the component whose turn it is may see ready; needs a credit and a tag slot.
    assign can_issue = (credits != 4'd0) && !fifo_full;
    assign y_ready   = (state == S_ISSUE_Y)  && can_issue;
    assign cb_ready  = (state == S_ISSUE_CB) && can_issue;
    assign cr_ready  = (state == S_ISSUE_CR) && can_issue;
    assign y_q_en    = y_valid  & y_ready;
    assign cb_q_en   = cb_valid & cb_ready;
    assign cr_q_en   = cr_valid & cr_ready;
    assign issue     = y_q_en | cb_q_en | cr_q_en;

    assign push_tag.comp = (state == S_ISSUE_Y) ? 2'd0 : (state == S_ISSUE_CB) ? 2'd1 : 2'd2;
    assign push_tag.blk  = (state == S_ISSUE_Y) ? y_idx : 2'd0;
    assign push_tag.last = (state == S_ISSUE_CR) && ((mcu_cnt + 16'd1) == num_mcus_r);

    // Output side: any quantizer out_enable is a tagged block; tag fields read 0 when nothing is in flight.
    assign any_done   = y_q_done | cb_q_done | cr_q_done;
    assign pop        = any_done & !fifo_empty;
    assign multi_done = (y_q_done & cb_q_done) | (y_q_done & cr_q_done) | (cb_q_done & cr_q_done);
    assign done_comp  = y_q_done ? 2'd0 : cb_q_done ? 2'd1 : 2'd2;
    assign out_valid  = any_done;
    assign out_comp   = fifo_empty ? 2'd0 : head.comp;
    assign out_blk    = fifo_empty ? 2'd0 : head.blk;
    assign out_last   = fifo_empty ? 1'b0 : head.last;

    assign cr_ovf  = credit_return && !issue && (credits == 4'(CREDITS));
    assign err_evt = (any_done & fifo_empty) | (pop & (done_comp != head.comp)) | multi_done | cr_ovf;
    assign busy    = (state != S_IDLE);

    // Next-state: walk Y x Y_PER_MCU, Cb, Cr per MCU, then drain in-flight tags.
    always_comb begin
        state_nxt   = state;
        y_idx_nxt   = y_idx;
        mcu_cnt_nxt = mcu_cnt;
        done_nxt    = 1'b0;
        start_acc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc   = 1'b1;
                    mcu_cnt_nxt = 16'd0;
                    y_idx_nxt   = 2'd0;
                    if (num_mcus == 16'd0) done_nxt  = 1'b1;
                    else                   state_nxt = S_ISSUE_Y;
                end
            end
            S_ISSUE_Y: begin
                if (y_q_en) begin
                    if (y_idx == 2'(Y_PER_MCU - 1)) begin
                        y_idx_nxt = 2'd0;
                        state_nxt = S_ISSUE_CB;
                    end else begin
                        y_idx_nxt = y_idx + 2'd1;
                    end
                end
            end
            S_ISSUE_CB: begin
                if (cb_q_en) state_nxt = S_ISSUE_CR;
            end
            S_ISSUE_CR: begin
                if (cr_q_en) begin
                    mcu_cnt_nxt = mcu_cnt + 16'd1;
                    y_idx_nxt   = 2'd0;
                    state_nxt   = (mcu_cnt_nxt == num_mcus_r) ? S_DRAIN : S_ISSUE_Y;
                end
            end
            S_DRAIN: begin
                // The empty check keeps the FSM from wedging if error pops emptied the FIFO early.
                if ((pop && (fifo_cnt == {{AW{1'b0}}, 1'b1})) || fifo_empty) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control state, counters, credits, tag pointers and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            y_idx      <= 2'd0;
            mcu_cnt    <= 16'd0;
            num_mcus_r <= 16'd0;
            credits    <= 4'(CREDITS);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state   <= state_nxt;
            y_idx   <= y_idx_nxt;
            mcu_cnt <= mcu_cnt_nxt;
            done    <= done_nxt;
            if (start_acc) num_mcus_r <= num_mcus;
            if (issue && !credit_return)
                credits <= credits - 4'd1;
            else if (!issue && credit_return && !cr_ovf)
                credits <= credits + 4'd1;
            if (issue) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (start_acc)    err <= err_evt;
            else if (err_evt) err <= 1'b1;
        end
    end

    // Tag storage; no reset needed since the pointers define validity.
    always_ff @(posedge clk) begin
        if (issue) fifo[wr_ptr[AW-1:0]] <= push_tag;
    end

endmodule

// File: tb/tb_quant_mcu_sequencer.sv
// Directed bench for quant_mcu_sequencer with 4-stage quantizer and credit-return models.
module tb_quant_mcu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_mcus;
    logic        y_valid, cb_valid, cr_valid;
    logic        y_ready, cb_ready, cr_ready;
    logic        y_q_en, cb_q_en, cr_q_en;
    logic        y_q_done, cb_q_done, cr_q_done;
    logic        credit_return;
    logic        out_valid;
    logic [1:0]  out_comp, out_blk;
    logic        out_last, busy, done, err;

    // Bench-side controls
    logic        qm_en, auto_cr, cr_man, y_inj, cb_inj, sb_en;
    logic [3:0]  y_pipe, cb_pipe, cr_pipe, ret_pipe;

    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    logic [4:0]  sb[$];
    int          ev_comp[$];
    int          ev_cyc[$];
    int          tr_y, tr_mcu, tr_frame;
    logic        frame_done;
    int          done_cyc, last_pop;

    quant_mcu_sequencer #(.Y_PER_MCU(4), .CREDITS(4), .TAG_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_mcus(num_mcus),
        .y_valid(y_valid), .y_ready(y_ready),
        .cb_valid(cb_valid), .cb_ready(cb_ready),
        .cr_valid(cr_valid), .cr_ready(cr_ready),
        .y_q_en(y_q_en), .cb_q_en(cb_q_en), .cr_q_en(cr_q_en),
        .y_q_done(y_q_done), .cb_q_done(cb_q_done), .cr_q_done(cr_q_done),
        .credit_return(credit_return),
        .out_valid(out_valid), .out_comp(out_comp), .out_blk(out_blk), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Quantizer latency model (out_enable 4 cycles after enable) and downstream credit return.
    always @(posedge clk) begin
        if (rst) begin
            y_pipe <= '0; cb_pipe <= '0; cr_pipe <= '0; ret_pipe <= '0;
        end else begin
            y_pipe   <= {y_pipe[2:0], y_q_en};
            cb_pipe  <= {cb_pipe[2:0], cb_q_en};
            cr_pipe  <= {cr_pipe[2:0], cr_q_en};
            ret_pipe <= {ret_pipe[2:0], out_valid & auto_cr};
        end
    end

    assign y_q_done      = (qm_en & y_pipe[3]) | y_inj;
    assign cb_q_done     = (qm_en & cb_pipe[3]) | cb_inj;
    assign cr_q_done     = qm_en & cr_pipe[3];
    assign credit_return = ret_pipe[3] | cr_man;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge (log issues, push/pop scoreboard), then step past posedge.
    task automatic cyc();
        logic [1:0] c;
        logic [1:0] b;
        logic       l;
        logic [4:0] e;
        @(negedge clk);
        if (y_q_en | cb_q_en | cr_q_en) begin
            chk("qen_onehot", 32'($onehot({y_q_en, cb_q_en, cr_q_en})), 32'd1);
            c = y_q_en ? 2'd0 : cb_q_en ? 2'd1 : 2'd2;
            b = (c == 2'd0) ? 2'(tr_y) : 2'd0;
            l = (c == 2'd2) && (tr_mcu + 1 == tr_frame);
            ev_comp.push_back(int'(c));
            ev_cyc.push_back(cyc_n);
            if (sb_en) sb.push_back({c, b, l});
            if (c == 2'd0) tr_y = (tr_y == 3) ? 0 : tr_y + 1;
            if (c == 2'd2) tr_mcu++;
        end
        if (out_valid && sb_en) begin
            last_pop = cyc_n;
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_tag", 32'({out_comp, out_blk, out_last}), 32'(e));
            end
        end
        if (done) begin
            frame_done = 1'b1;
            done_cyc   = cyc_n;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic start_frame(input int n);
        num_mcus   = 16'(n);
        start      = 1'b1;
        tr_y       = 0;
        tr_mcu     = 0;
        tr_frame   = n;
        frame_done = 1'b0;
        ev_comp.delete();
        ev_cyc.delete();
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (frame_done) break;
            cyc();
        end
        chk(tag, 32'(frame_done), 32'd1);
    endtask

    task automatic rst_dut();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_mcus = '0;
        y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0;
        qm_en = 1'b1; auto_cr = 1'b1; cr_man = 1'b0; y_inj = 1'b0; cb_inj = 1'b0; sb_en = 1'b1;
        tr_y = 0; tr_mcu = 0; tr_frame = 0; frame_done = 1'b0; done_cyc = 0; last_pop = 0;
        cyc();
        rst_dut();

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_y_ready", 32'(y_ready), 0);
        chk("rst_cb_ready", 32'(cb_ready), 0);
        chk("rst_cr_ready", 32'(cr_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_done", 32'(done), 0);

        // Basic one-MCU frame
        y_valid = 1'b1; cb_valid = 1'b1; cr_valid = 1'b1;
        start_frame(1);
        wait_done("t1_done_seen");
        chk("t1_nissue", 32'(ev_comp.size()), 6);
        for (int i = 0; i < 6; i++)
            chk("t1_order", 32'(ev_comp[i]), (i < 4) ? 0 : (i == 4) ? 1 : 2);
        chk("t1_y_consecutive", 32'(ev_cyc[3] - ev_cyc[0]), 3);
        chk("t1_done_latency", 32'(done_cyc - last_pop), 1);
        chk("t1_err", 32'(err), 0);
        chk("t1_sb_empty", 32'(sb.size()), 0);
        repeat (8) cyc();
        chk("t1_idle", 32'(busy), 0);

        // Credit stall: only manual credit returns
        auto_cr = 1'b0;
        start_frame(1);
        repeat (10) cyc();
        chk("t2_nissue_stall", 32'(ev_comp.size()), 4);
        chk("t2_cb_ready_stall", 32'(cb_ready), 0);
        chk("t2_y_ready_stall", 32'(y_ready), 0);
        cr_man = 1'b1; cyc(); cr_man = 1'b0;
        repeat (4) cyc();
        chk("t2_nissue_one", 32'(ev_comp.size()), 5);
        chk("t2_released_cb", 32'(ev_comp[4]), 1);
        cr_man = 1'b1; cyc(); cr_man = 1'b0;
        wait_done("t2_done_seen");
        chk("t2_nissue_all", 32'(ev_comp.size()), 6);
        cr_man = 1'b1; repeat (4) cyc(); cr_man = 1'b0;
        chk("t2_err", 32'(err), 0);
        auto_cr = 1'b1;

        // Valid gap after Y1
        start_frame(1);
        cyc();
        cyc();
        y_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_y_ready_hold", 32'(y_ready), 1);
            chk("t3_cb_ready_low", 32'(cb_ready), 0);
            cyc();
        end
        y_valid = 1'b1;
        wait_done("t3_done_seen");
        chk("t3_nissue", 32'(ev_comp.size()), 6);
        repeat (8) cyc();

        // Zero-MCU frame
        start_frame(0);
        chk("t4_done_pulse", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        cyc();
        chk("t4_done_clear", 32'(done), 0);
        chk("t4_no_issue", 32'(ev_comp.size()), 0);

        // Two-MCU frame with an ignored start mid-frame
        start_frame(2);
        repeat (3) cyc();
        num_mcus = 16'd0; start = 1'b1; cyc(); start = 1'b0;
        wait_done("t4b_done_seen");
        chk("t4b_nissue", 32'(ev_comp.size()), 12);
        chk("t4b_err", 32'(err), 0);
        repeat (8) cyc();

        // Errors: credit overflow, cleared by a new start
        sb_en = 1'b0; auto_cr = 1'b0; qm_en = 1'b0;
        cr_man = 1'b1; cyc(); cr_man = 1'b0;
        chk("t5_ovf_err", 32'(err), 1);
        start_frame(0);
        chk("t5_start_clears", 32'(err), 0);
        cyc();

        // Errors: wrong component at head, then empty-FIFO done
        start_frame(1);
        cyc();
        cyc();
        y_valid = 1'b0;
        chk("t5_nissue", 32'(ev_comp.size()), 2);
        chk("t5_err_clean", 32'(err), 0);
        cb_inj = 1'b1;
        #1;
        chk("t5_mis_valid", 32'(out_valid), 1);
        chk("t5_mis_head_comp", 32'(out_comp), 0);
        chk("t5_mis_head_blk", 32'(out_blk), 0);
        cyc(); cb_inj = 1'b0;
        chk("t5_mis_err", 32'(err), 1);
        y_inj = 1'b1;
        #1;
        chk("t5_popped_blk", 32'(out_blk), 1);
        cyc(); y_inj = 1'b0;
        y_inj = 1'b1;
        #1;
        chk("t5_empty_valid", 32'(out_valid), 1);
        chk("t5_empty_fields", 32'({out_comp, out_blk, out_last}), 0);
        cyc(); y_inj = 1'b0;

        // Reset mid-frame after three issues
        rst_dut();
        chk("t6_err_rst", 32'(err), 0);
        y_valid = 1'b1;
        start_frame(1);
        cyc(); cyc(); cyc();
        y_valid = 1'b0;
        chk("t6_nissue", 32'(ev_comp.size()), 3);
        rst_dut();
        chk("t6_busy", 32'(busy), 0);
        chk("t6_y_ready", 32'(y_ready), 0);
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_err", 32'(err), 0);
        cr_man = 1'b1; cyc(); cr_man = 1'b0;
        chk("t6_credits_full", 32'(err), 1);
        rst_dut();
        y_inj = 1'b1; cyc(); y_inj = 1'b0;
        chk("t6_late_done_err", 32'(err), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
